// File: rtl/gemm_drain_if.sv
// rtl/gemm_drain_if.sv - column stream from the GEMM drain to the next-layer function module
interface gemm_drain_if #(
    parameter int ROWS       = 2,
    parameter int DATA_WIDTH = 16,
    parameter int FLAG_WIDTH = 4,
    parameter int N_COLS     = 1
);
    logic                       o_valid;
    logic                       i_ready;
    logic [ROWS*DATA_WIDTH-1:0] o_data;
    logic [ROWS*FLAG_WIDTH-1:0] o_flag;
    logic [N_COLS-1:0]          o_col;
    logic                       o_last;

    modport master (
        output o_valid, o_data, o_flag, o_col, o_last,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_data, o_flag, o_col, o_last,
        output i_ready
    );
endinterface

// File: rtl/gemm_drain.sv
// rtl/gemm_drain.sv - settles, then walks the array column select and streams each column out
module gemm_drain #(
    parameter int ROWS          = 2,
    parameter int COLS          = 2,
    parameter int N_COLS        = 1,
    parameter int DATA_WIDTH    = 16,
    parameter int FLAG_WIDTH    = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int SETTLE_W      = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic [N_COLS-1:0]          o_addr,
    input  logic [ROWS*DATA_WIDTH-1:0] i_data_acc,
    input  logic [ROWS*FLAG_WIDTH-1:0] i_data_flag,
    gemm_drain_if.master               dout,
    output logic                       o_flag_any,
    output logic                       o_done
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [N_COLS-1:0]   LAST_COL    = N_COLS'(COLS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);

    logic [2:0]                 state_q, state_d;
    logic [N_COLS-1:0]          cnt_q, cnt_d;
    logic [SETTLE_W-1:0]        settle_q, settle_d;
    logic                       valid_q, valid_d;
    logic [ROWS*DATA_WIDTH-1:0] data_q, data_d;
    logic [ROWS*FLAG_WIDTH-1:0] flag_q, flag_d;
    logic [N_COLS-1:0]          col_q, col_d;
    logic                       last_q, last_d;
    logic                       flag_any_q, flag_any_d;
    logic                       xfer;

    assign xfer = valid_q && dout.i_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        valid_d    = valid_q;
        data_d     = data_q;
        flag_d     = flag_q;
        col_d      = col_q;
        last_d     = last_q;
        flag_any_d = flag_any_q;

        if (xfer) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    flag_any_d = 1'b0;
                    cnt_d      = '0;
                    if (SETTLE_CYCLES > 0) begin
                        settle_d = SETTLE_LOAD;
                        state_d  = S_SETTLE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_READ;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            S_READ: begin
                // Load whenever the output register is empty or draining this cycle.
                if (!valid_q || dout.i_ready) begin
                    valid_d    = 1'b1;
                    data_d     = i_data_acc;
                    flag_d     = i_data_flag;
                    col_d      = cnt_q;
                    last_d     = (cnt_q == LAST_COL);
                    flag_any_d = flag_any_q | (|i_data_flag);
                    if (cnt_q == LAST_COL) begin
                        state_d = S_FLUSH;
                    end else begin
                        cnt_d = cnt_q + N_COLS'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (xfer) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            settle_q   <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            flag_q     <= '0;
            col_q      <= '0;
            last_q     <= 1'b0;
            flag_any_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            settle_q   <= settle_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            flag_q     <= flag_d;
            col_q      <= col_d;
            last_q     <= last_d;
            flag_any_q <= flag_any_d;
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_addr       = cnt_q;
    assign o_flag_any   = flag_any_q;
    assign dout.o_valid = valid_q;
    assign dout.o_data  = data_q;
    assign dout.o_flag  = flag_q;
    assign dout.o_col   = col_q;
    assign dout.o_last  = last_q;
endmodule
